// File: rtl/simon_pkg.sv
// Shared encodings and constants for the Simon colour-sequence builder.
package simon_pkg;

    typedef enum logic [1:0] {
        MODE_FULL   = 2'b00,
        MODE_APPEND = 2'b01,
        MODE_RESEED = 2'b10
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIN  = 2'b10
    } state_t;

    localparam logic [15:0] DEFAULT_TAPS = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    // The reserved encoding 2'b11 behaves as a reseed.
    function automatic mode_e decode_mode(input logic [1:0] m);
        case (m)
            2'b00:   return MODE_FULL;
            2'b01:   return MODE_APPEND;
            default: return MODE_RESEED;
        endcase
    endfunction

endpackage

// File: rtl/seq_lfsr.sv
// Galois right-shift LFSR; load has priority over step, state persists otherwise.
module seq_lfsr #(
    parameter int                LFSR_W = 16,
    parameter logic [LFSR_W-1:0] TAPS   = 16'hB400,
    parameter logic [LFSR_W-1:0] SEED   = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              step,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    output logic [LFSR_W-1:0] state
);

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= SEED;
        end else if (load) begin
            state <= load_val;
        end else if (step) begin
            state <= state[0] ? ((state >> 1) ^ TAPS) : (state >> 1);
        end
    end

endmodule

// File: rtl/sequence_builder.sv
// Fills the Simon colour-sequence RAM: full load, single append or reseed/clear,
// with an optional rule that forbids two equal consecutive colours.
module sequence_builder
    import simon_pkg::*;
#(
    parameter int                N      = 32,
    parameter int                CW     = 2,
    parameter int                LFSR_W = 16,
    parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(DEFAULT_SEED),
    parameter int                AW     = $clog2(N)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [LFSR_W-1:0] seed_in,
    input  logic              no_repeat,
    output logic              write_en,
    output logic [AW-1:0]     wr_addr,
    output logic [CW-1:0]     wr_data,
    output logic [AW:0]       length,
    output logic              full,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [LFSR_W-1:0] TAPS  = LFSR_W'(DEFAULT_TAPS);
    localparam logic [AW:0]       N_VAL = (AW+1)'(N);

    state_t            r_state;
    state_t            w_state_nx;
    mode_e             r_mode;
    mode_e             w_cmd;
    logic              r_no_repeat;
    logic [AW:0]       r_cnt;
    logic [AW:0]       r_length;
    logic [CW-1:0]     r_prev;

    logic              w_write;
    logic [AW-1:0]     w_addr;
    logic              w_compare;
    logic              w_nr;
    logic              w_done;
    logic              w_err;
    logic              w_load;
    logic [AW:0]       w_length_nx;
    logic [CW-1:0]     w_cand;
    logic [CW-1:0]     w_data;
    logic [LFSR_W-1:0] w_lfsr;
    logic [LFSR_W-1:0] w_load_val;
    logic              w_unused_lfsr;

    assign w_cmd         = decode_mode(mode);
    assign w_load_val    = (seed_in == '0) ? SEED : seed_in;
    assign w_cand        = w_lfsr[CW-1:0];
    assign w_data        = (w_nr && w_compare && (w_cand == r_prev)) ? w_cand + 1'b1 : w_cand;
    assign w_unused_lfsr = ^w_lfsr[LFSR_W-1:CW];
    assign length        = r_length;

    seq_lfsr #(
        .LFSR_W (LFSR_W),
        .TAPS   (TAPS),
        .SEED   (SEED)
    ) u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .step     (w_write),
        .load     (w_load),
        .load_val (w_load_val),
        .state    (w_lfsr)
    );

    // FIN also accepts start, so a new command can be taken on the edge that ends done.
    always_comb begin
        // NOTE: every combinational output is defaulted first so no path can infer a latch.
        w_state_nx  = r_state;
        w_write     = 1'b0;
        w_addr      = r_cnt[AW-1:0];
        w_compare   = 1'b1;
        w_nr        = r_no_repeat;
        w_done      = 1'b0;
        w_err       = 1'b0;
        w_load      = 1'b0;
        w_length_nx = r_length;
        case (r_state)
            RUN: begin
                if (r_mode == MODE_FULL && r_cnt != N_VAL) begin
                    w_write = 1'b1;
                end else begin
                    w_state_nx = FIN;
                    w_done     = 1'b1;
                end
            end
            default: begin
                w_state_nx = IDLE;
                if (start) begin
                    w_nr = no_repeat;
                    case (w_cmd)
                        MODE_FULL: begin
                            w_state_nx = RUN;
                            w_write    = 1'b1;
                            w_addr     = '0;
                            w_compare  = 1'b0;
                        end
                        MODE_APPEND: begin
                            if (r_length == N_VAL) begin
                                w_state_nx = FIN;
                                w_done     = 1'b1;
                                w_err      = 1'b1;
                            end else begin
                                w_state_nx = RUN;
                                w_write    = 1'b1;
                                w_addr     = r_length[AW-1:0];
                                w_compare  = (r_length != '0);
                            end
                        end
                        default: begin
                            w_state_nx  = FIN;
                            w_done      = 1'b1;
                            w_load      = 1'b1;
                            w_length_nx = '0;
                        end
                    endcase
                end
            end
        endcase
        if (w_write) begin
            w_length_nx = {1'b0, w_addr} + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_mode      <= MODE_FULL;
            r_no_repeat <= 1'b0;
            r_cnt       <= '0;
            r_length    <= '0;
            r_prev      <= '0;
            write_en    <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            full        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_length <= w_length_nx;
            full     <= (w_length_nx == N_VAL);
            busy     <= (w_state_nx != IDLE);
            write_en <= w_write;
            done     <= w_done;
            err      <= w_err;
            if (start && r_state != RUN) begin
                r_mode      <= w_cmd;
                r_no_repeat <= no_repeat;
            end
            if (w_write) begin
                wr_addr <= w_addr;
                wr_data <= w_data;
                r_prev  <= w_data;
                r_cnt   <= {1'b0, w_addr} + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sequence_builder.sv
// Self-checking bench: per-cycle comparison against a transaction-level model,
// directed scenarios with hand-computed sequences, then randomized commands.
module tb_sequence_builder;

    localparam int          N    = 4;
    localparam int          CW   = 2;
    localparam int          AW   = 2;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam logic [15:0] TAPS = 16'hB400;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [1:0]    mode;
    logic [15:0]   seed_in;
    logic          no_repeat;
    logic          write_en;
    logic [AW-1:0] wr_addr;
    logic [CW-1:0] wr_data;
    logic [AW:0]   length;
    logic          full;
    logic          busy;
    logic          done;
    logic          err;

    sequence_builder #(
        .N      (N),
        .CW     (CW),
        .LFSR_W (16),
        .SEED   (SEED)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mode      (mode),
        .seed_in   (seed_in),
        .no_repeat (no_repeat),
        .write_en  (write_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .length    (length),
        .full      (full),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [CW-1:0] data;
        logic          done;
        logic          err;
    } exp_t;

    exp_t          exp_q[$];
    logic [15:0]   m_lfsr;
    int            m_len;
    logic [CW-1:0] m_prev;

    int            checks = 0;
    int            errors = 0;
    int            cyc    = 0;
    logic [CW-1:0] wlog[8];
    int            nw;
    logic          err_seen;
    int            lat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_lfsr = SEED;
        m_len  = 0;
        m_prev = '0;
    endtask

    task automatic model_write(input int addr, input logic nr, input logic cmp);
        logic [CW-1:0] cand;
        logic [CW-1:0] d;
        exp_t          e;
        cand = m_lfsr[CW-1:0];
        d    = (nr && cmp && cand == m_prev) ? CW'((int'(cand) + 1) % (1 << CW)) : cand;
        e      = '0;
        e.we   = 1'b1;
        e.addr = AW'(addr);
        e.data = d;
        exp_q.push_back(e);
        m_prev = d;
        m_lfsr = lfsr_next(m_lfsr);
    endtask

    task automatic model_done(input logic e_err);
        exp_t e;
        e      = '0;
        e.done = 1'b1;
        e.err  = e_err;
        exp_q.push_back(e);
    endtask

    // Called on each rising edge: retires the cycle just ended, queues the
    // whole cycle-by-cycle output of any command accepted at this edge.
    task automatic model_edge();
        logic accept;
        if (reset) begin
            model_reset();
            return;
        end
        accept = start && (exp_q.size() == 0 || exp_q[0].done);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        if (accept) begin
            case (mode)
                2'b00: begin
                    for (int i = 0; i < N; i++) model_write(i, no_repeat, i != 0);
                    m_len = N;
                    model_done(1'b0);
                end
                2'b01: begin
                    if (m_len == N) begin
                        model_done(1'b1);
                    end else begin
                        model_write(m_len, no_repeat, m_len != 0);
                        m_len++;
                        model_done(1'b0);
                    end
                end
                default: begin
                    m_lfsr = (seed_in == 16'h0) ? SEED : seed_in;
                    m_len  = 0;
                    model_done(1'b0);
                end
            endcase
        end
    endtask

    task automatic compare();
        exp_t e;
        logic idle;
        idle = (exp_q.size() == 0);
        e    = idle ? exp_t'('0) : exp_q[0];
        check("write_en", 32'(write_en), 32'(e.we));
        if (e.we) begin
            check("wr_addr", 32'(wr_addr), 32'(e.addr));
            check("wr_data", 32'(wr_data), 32'(e.data));
        end
        check("done", 32'(done), 32'(e.done));
        check("err", 32'(err), 32'(e.err));
        check("busy", 32'(busy), 32'(!idle));
        if (idle) begin
            check("length", 32'(length), 32'(m_len));
            check("full", 32'(full), 32'(m_len == N));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Issues one command, returns the done latency in cycles after the sampling
    // edge and logs the data of every write seen until done.
    task automatic run_cmd(input logic [1:0] m, input logic [15:0] s, input logic nr);
        mode      = m;
        seed_in   = s;
        no_repeat = nr;
        start     = 1'b1;
        nw        = 0;
        err_seen  = 1'b0;
        lat       = -1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            if (write_en && nw < 8) begin
                wlog[nw] = wr_data;
                nw++;
            end
            if (done) begin
                lat      = i;
                err_seen = err;
                break;
            end
            tick();
        end
        if (lat < 0) check("done_timeout", 32'(lat), 32'(0));
        tick();
    endtask

    initial begin
        int writes;
        int dones;
        reset     = 1'b1;
        start     = 1'b0;
        mode      = 2'b00;
        seed_in   = 16'h0;
        no_repeat = 1'b0;
        model_reset();
        repeat (2) tick();
        reset = 1'b0;
        tick();
        check("rst_length", 32'(length), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));

        // FULL, no repeat rule: 01,00,00,00 with done at k+5.
        run_cmd(2'b00, 16'h0, 1'b0);
        check("full_lat", 32'(lat), 32'(5));
        check("full_nw", 32'(nw), 32'(4));
        check("full_d0", 32'(wlog[0]), 32'(1));
        check("full_d1", 32'(wlog[1]), 32'(0));
        check("full_d2", 32'(wlog[2]), 32'(0));
        check("full_d3", 32'(wlog[3]), 32'(0));
        check("full_len", 32'(length), 32'(4));
        check("full_flag", 32'(full), 32'(1));

        // FULL with the no-repeat rule: 01,00,01,00.
        do_reset();
        run_cmd(2'b00, 16'h0, 1'b1);
        check("nr_d0", 32'(wlog[0]), 32'(1));
        check("nr_d1", 32'(wlog[1]), 32'(0));
        check("nr_d2", 32'(wlog[2]), 32'(1));
        check("nr_d3", 32'(wlog[3]), 32'(0));

        // RESEED with zero seed falls back to SEED, then grow by APPEND.
        run_cmd(2'b10, 16'h0, 1'b0);
        check("reseed_lat", 32'(lat), 32'(1));
        check("reseed_nw", 32'(nw), 32'(0));
        check("reseed_len", 32'(length), 32'(0));
        for (int a = 0; a < 4; a++) begin
            run_cmd(2'b01, 16'h0, 1'b0);
            check("app_lat", 32'(lat), 32'(2));
            check("app_nw", 32'(nw), 32'(1));
            check("app_data", 32'(wlog[0]), 32'((a == 0) ? 1 : 0));
            check("app_len", 32'(length), 32'(a + 1));
        end
        run_cmd(2'b01, 16'h0, 1'b0);
        check("app_full_lat", 32'(lat), 32'(1));
        check("app_full_err", 32'(err_seen), 32'(1));
        check("app_full_nw", 32'(nw), 32'(0));
        check("app_full_len", 32'(length), 32'(4));

        // RESEED 0001: first two FULL colours are 01 then 00.
        run_cmd(2'b10, 16'h0001, 1'b0);
        check("rs1_len", 32'(length), 32'(0));
        run_cmd(2'b00, 16'h0, 1'b0);
        check("rs1_d0", 32'(wlog[0]), 32'(1));
        check("rs1_d1", 32'(wlog[1]), 32'(0));

        // start pulsed during the second RUN cycle is ignored.
        mode      = 2'b00;
        no_repeat = 1'b0;
        start     = 1'b1;
        tick();
        writes = 0;
        dones  = 0;
        for (int i = 1; i <= 8; i++) begin
            writes += int'(write_en);
            dones  += int'(done);
            start = (i == 2);
            mode  = (i == 2) ? 2'b01 : 2'b00;
            tick();
        end
        start = 1'b0;
        check("busy_writes", 32'(writes), 32'(N));
        check("busy_dones", 32'(dones), 32'(1));

        // Asynchronous reset in the middle of a FULL load.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #2;
        reset = 1'b1;
        #1;
        check("async_we", 32'(write_en), 32'(0));
        check("async_len", 32'(length), 32'(0));
        check("async_busy", 32'(busy), 32'(0));
        model_reset();
        tick();
        reset = 1'b0;
        tick();
        run_cmd(2'b00, 16'h0, 1'b0);
        check("async_restart_d0", 32'(wlog[0]), 32'(1));

        // Randomized commands, including starts while busy and reserved mode.
        for (int i = 0; i < 400; i++) begin
            start     = ($urandom_range(0, 2) == 0);
            mode      = 2'($urandom_range(0, 3));
            seed_in   = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            no_repeat = 1'($urandom_range(0, 1));
            tick();
        end
        start = 1'b0;
        repeat (10) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/sequence_builder.md
# sequence_builder

Parametrised successor to the Simon sequence loader. It owns an internal Galois LFSR and fills the game's colour-sequence RAM in one of three modes:
- full-sequence load;
- single-entry append, for round-by-round growth;
- reseed/clear.

It supports generic colour width and depth, an optional no-immediate-repeat rule, and a start/busy/done handshake toward the game controller.

## Interface
- N, 32: maximum sequence length (RAM depth), N ≥ 2
- CW, 2: colour width in bits (2^CW colours)
- LFSR_W, 16: LFSR width
- SEED, 16'hACE1: reset and fallback LFSR seed, must be non-zero
- AW, $clog2(N): derived RAM address width
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  command strobe, sampled only in IDLE
- mode  in  2  00 FULL, 01 APPEND, 10 RESEED, 11 reserved (treated as RESEED)
- seed_in  in  LFSR_W  seed for RESEED
- no_repeat  in  1  forbid equal consecutive colours; sampled with start
- write_en  out  1  RAM write strobe
- wr_addr  out  AW  RAM write address
- wr_data  out  CW  RAM write data
- length  out  AW+1  number of valid entries in RAM
- full  out  1  length == N
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse: APPEND rejected because full

## Operation
- FSM states: IDLE, RUN, FIN.
  - IDLE: waits for start; mode and no_repeat are latched.
  - RUN: performs the writes.
  - FIN: asserts done, then returns to IDLE.
- FULL: writes N entries at addresses 0..N-1 in consecutive cycles. length becomes N.
- APPEND with length < N: one write at wr_addr = length. length increments on that write's edge.
- APPEND with full = 1: no write. err and done pulse together. length is unchanged.
- RESEED: the LFSR loads seed_in, or SEED if seed_in == 0 (prevents lockup). length clears to 0. No write.
- LFSR, Galois right-shift with taps 16'hB400 for LFSR_W = 16:
  - if lsb = 1: next = (s >> 1) ^ TAPS
  - else: next = s >> 1
  - It steps only on write cycles. Its state persists across commands (APPEND continues the same stream).
- Candidate colour = s[CW-1:0].
- With no_repeat = 1, if the candidate equals the previously written colour, wr_data = candidate + 1 mod 2^CW.
  - The comparison is against the last adjusted value actually written.
  - There is no comparison at address 0 in FULL mode.
  - APPEND compares against the last write of any mode. It does not compare if length == 0.
- start while busy: ignored. start is not queued.

## Timing
- Reset (async): state IDLE, LFSR = SEED, length = 0, previous-colour register = 0. write_en, wr_addr, wr_data, busy, done, err, full = 0. All outputs are registered.
- Reset mid-RUN aborts immediately. Partial RAM contents are abandoned; length reads 0.
- start sampled high at edge k:
  - busy rises after edge k.
  - FULL: write_en is high for cycles k+1..k+N; done is high in cycle k+N+1.
  - APPEND: write in cycle k+1; done in cycle k+2.
  - RESEED, or APPEND when full: done (plus err if applicable) in cycle k+1.
- busy falls in the same cycle done falls. A new start may be sampled on the edge that ends the done cycle.
- wr_addr and wr_data are valid only while write_en = 1; otherwise they hold their last value.

## Structure
- Package `simon_pkg`:
  - mode encodings (MODE_FULL, MODE_APPEND, MODE_RESEED)
  - FSM state typedef
  - default LFSR taps and SEED constants
- Sub-module `seq_lfsr` (parameters LFSR_W, TAPS, SEED). Ports: clk, reset, step, load, load_val, state.
- FSM, address counter, length register and no-repeat logic live in the top level.

## Test plan
- Reset, then FULL with N = 4, CW = 2, no_repeat = 0 → writes to addresses 0,1,2,3 with data 01,00,00,00. done is high in cycle k+5. length = 4, full = 1.
- Reset, then FULL with no_repeat = 1 → data 01,00,01,00. No two consecutive entries are equal.
- RESEED with seed_in = 0, then APPEND ×4 → writes to addresses 0..3 with data 01,00,00,00. Each done arrives 2 cycles after its start. The fifth APPEND gives err = done = 1 in cycle k+1, no write_en, and length stays 4.
- RESEED with seed_in = 16'h0001 → length = 0 and no write_en. The following FULL's first wr_data = 01. The second wr_data = 2'b00 (state 16'hB400).
- start pulsed during FULL RUN cycle 2 → ignored: exactly N writes and a single done pulse.
- Reset asserted in cycle k+2 of FULL → write_en drops without waiting for a clock edge, length = 0. After release, the LFSR restarts from SEED and the first write is 01.
